// File: rtl/control_multi_hs.sv
// Multi-cycle RV32 control unit with memory / mul-div handshakes, a memory
// wait timeout that traps, and cycle / retired-instruction counters.
// Optional feature: define CONTROL_MULTI_HS_MULDIV_EN to enable the MULDIV
// state for R-type instructions with instr[25]=1.
module control_multi_hs #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0004
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [6:0]       iOp,
    input  logic             iF7b0,
    input  logic             iMemReady,
    input  logic             iMdDone,
    output logic             oIRWrite,
    output logic             oMemWrite,
    output logic             oMemRead,
    output logic             oIorD,
    output logic             oPCWrite,
    output logic             oPCWriteCond,
    output logic             oRegWrite,
    output logic             oOriAALU,
    output logic             oMdStart,
    output logic             oTrap,
    output logic [1:0]       oOriPC,
    output logic [1:0]       oOriBALU,
    output logic [1:0]       oMem2Reg,
    output logic [1:0]       oALUOp,
    output logic [1:0]       oTrapCause,
    output logic [31:0]      oTrapVec,
    output logic [3:0]       oState,
    output logic [CNT_W-1:0] oCycles,
    output logic [CNT_W-1:0] oInstret
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExe    = 4'd2,
        StMem    = 4'd3,
        StWb     = 4'd4,
        StMulDiv = 4'd5,
        StTrap   = 4'd6
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [7:0] TimeoutW = 8'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [7:0]       wait_inc;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cycles_q, instret_q;
    logic             retire;
    logic             legal_op;
    logic             md_trap;
    logic             timeout;

    assign wait_inc = wait_q + 8'd1;
    // Timeout fires in the cycle that would make the wait count reach the limit.
    assign timeout  = !iMemReady && (wait_inc >= TimeoutW);

    // Opcode legality for DECODE.
    always_comb begin
        legal_op = 1'b0;
        case (iOp)
            OpLoad, OpStore, OpR, OpImm, OpBranch,
            OpJal, OpJalr, OpLui, OpAuipc: legal_op = 1'b1;
            default:                       legal_op = 1'b0;
        endcase
    end

`ifdef CONTROL_MULTI_HS_MULDIV_EN
    assign md_trap = 1'b0;
`else
    // M-extension is absent, so an R-type with instr[25]=1 is illegal.
    assign md_trap = (iOp == OpR) && iF7b0;
    logic unused_md;
    assign unused_md = iMdDone;
`endif

    // Next-state, retirement and strobe decode from present state and opcode.
    always_comb begin
        state_d      = StFetch;
        cause_d      = cause_q;
        retire       = 1'b0;
        oIRWrite     = 1'b0;
        oMemWrite    = 1'b0;
        oMemRead     = 1'b0;
        oIorD        = 1'b0;
        oPCWrite     = 1'b0;
        oPCWriteCond = 1'b0;
        oRegWrite    = 1'b0;
        oOriAALU     = 1'b0;
        oMdStart     = 1'b0;
        oTrap        = 1'b0;
        oOriPC       = 2'b00;
        oOriBALU     = 2'b00;
        oMem2Reg     = 2'b00;
        oALUOp       = 2'b00;
        case (state_q)
            StFetch: begin
                oMemRead = 1'b1;
                oOriBALU = 2'b01;
                if (iMemReady) begin
                    oIRWrite = 1'b1;
                    oPCWrite = 1'b1;
                    state_d  = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                end else begin
                    state_d = StFetch;
                end
            end
            StDecode: begin
                oOriBALU = 2'b10;
                if (!legal_op || md_trap) begin
                    state_d = StTrap;
                    cause_d = 2'b01;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                case (iOp)
                    OpLoad, OpStore: begin
                        oOriAALU = 1'b1;
                        oOriBALU = 2'b10;
                        state_d  = StMem;
                    end
                    OpR: begin
                        oALUOp   = 2'b10;
                        oOriAALU = 1'b1;
                        oOriBALU = 2'b00;
`ifdef CONTROL_MULTI_HS_MULDIV_EN
                        if (iF7b0) begin
                            oMdStart = 1'b1;
                            state_d  = StMulDiv;
                        end else begin
                            state_d = StWb;
                        end
`else
                        state_d = StWb;
`endif
                    end
                    OpImm: begin
                        oALUOp   = 2'b10;
                        oOriAALU = 1'b1;
                        oOriBALU = 2'b10;
                        state_d  = StWb;
                    end
                    OpBranch: begin
                        oALUOp       = 2'b01;
                        oOriAALU     = 1'b1;
                        oPCWriteCond = 1'b1;
                        oOriPC       = 2'b01;
                        retire       = 1'b1;
                    end
                    OpJal: begin
                        oRegWrite = 1'b1;
                        oMem2Reg  = 2'b10;
                        oPCWrite  = 1'b1;
                        oOriPC    = 2'b01;
                        retire    = 1'b1;
                    end
                    OpJalr: begin
                        oRegWrite = 1'b1;
                        oMem2Reg  = 2'b10;
                        oOriAALU  = 1'b1;
                        oOriBALU  = 2'b10;
                        oPCWrite  = 1'b1;
                        oOriPC    = 2'b00;
                        retire    = 1'b1;
                    end
                    OpLui, OpAuipc: state_d = StWb;
                    default:        state_d = StFetch;
                endcase
            end
            StMem: begin
                oIorD     = 1'b1;
                oMemRead  = (iOp == OpLoad);
                oMemWrite = (iOp == OpStore);
                if (iMemReady) begin
                    if (iOp == OpLoad) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                end else begin
                    state_d = StMem;
                end
            end
            StWb: begin
                oRegWrite = 1'b1;
                oMem2Reg  = (iOp == OpLoad) ? 2'b01 : 2'b00;
                retire    = 1'b1;
            end
            StMulDiv: begin
`ifdef CONTROL_MULTI_HS_MULDIV_EN
                if (iMdDone) begin
                    oRegWrite = 1'b1;
                    oMem2Reg  = 2'b11;
                    retire    = 1'b1;
                end else begin
                    state_d = StMulDiv;
                end
`else
                state_d = StFetch;
`endif
            end
            StTrap: begin
                oTrap    = 1'b1;
                oPCWrite = 1'b1;
                oOriPC   = 2'b10;
            end
            default: state_d = StFetch;
        endcase
    end

    // Wait counter runs only while FETCH or MEM is stalled; any state entry clears it.
    always_comb begin
        wait_d = 8'd0;
        if ((state_q == StFetch || state_q == StMem) && (state_d == state_q)) begin
            wait_d = wait_inc;
        end
    end

    // State, wait counter, trap cause and performance counters.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q   <= StFetch;
            wait_q    <= 8'd0;
            cause_q   <= 2'b00;
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            cycles_q  <= cycles_q + CNT_W'(1);
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign oTrapCause = cause_q;
    assign oTrapVec   = TRAP_VEC;
    assign oState     = state_q;
    assign oCycles    = cycles_q;
    assign oInstret   = instret_q;

endmodule

// File: tb/tb_control_multi_hs.sv
// Directed bench for control_multi_hs: expected per-cycle state/strobes are
// queued as stimulus is planned and compared as the DUT steps through them.
module tb_control_multi_hs;

    localparam int unsigned CntW = 8;

    logic            iCLK = 1'b0;
    logic            iRST_N;
    logic [6:0]      iOp;
    logic            iF7b0;
    logic            iMemReady;
    logic            iMdDone;
    logic            oIRWrite, oMemWrite, oMemRead, oIorD, oPCWrite, oPCWriteCond;
    logic            oRegWrite, oOriAALU, oMdStart, oTrap;
    logic [1:0]      oOriPC, oOriBALU, oMem2Reg, oALUOp, oTrapCause;
    logic [31:0]     oTrapVec;
    logic [3:0]      oState;
    logic [CntW-1:0] oCycles, oInstret;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       md;
        logic       rw;
        logic [1:0] m2r;
        logic       pcw;
        logic       mrd;
    } sb_t;

    sb_t sb[$];

    control_multi_hs #(
        .CNT_W      (CntW),
        .MEM_TIMEOUT(4),
        .TRAP_VEC   (32'h0000_0004)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iOp         (iOp),
        .iF7b0       (iF7b0),
        .iMemReady   (iMemReady),
        .iMdDone     (iMdDone),
        .oIRWrite    (oIRWrite),
        .oMemWrite   (oMemWrite),
        .oMemRead    (oMemRead),
        .oIorD       (oIorD),
        .oPCWrite    (oPCWrite),
        .oPCWriteCond(oPCWriteCond),
        .oRegWrite   (oRegWrite),
        .oOriAALU    (oOriAALU),
        .oMdStart    (oMdStart),
        .oTrap       (oTrap),
        .oOriPC      (oOriPC),
        .oOriBALU    (oOriBALU),
        .oMem2Reg    (oMem2Reg),
        .oALUOp      (oALUOp),
        .oTrapCause  (oTrapCause),
        .oTrapVec    (oTrapVec),
        .oState      (oState),
        .oCycles     (oCycles),
        .oInstret    (oInstret)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy, input logic md, input logic rw,
                        input logic [1:0] m2r, input logic pcw, input logic mrd);
        sb_t e;
        e.st = st; e.rdy = rdy; e.md = md; e.rw = rw; e.m2r = m2r; e.pcw = pcw; e.mrd = mrd;
        sb.push_back(e);
    endtask

    // Pops one expected entry per cycle, drives its handshakes and compares.
    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            iMemReady = e.rdy;
            iMdDone   = e.md;
            #1;
            chk("state", 32'(oState), 32'(e.st));
            chk("regwrite", 32'(oRegWrite), 32'(e.rw));
            chk("pcwrite", 32'(oPCWrite), 32'(e.pcw));
            chk("memread", 32'(oMemRead), 32'(e.mrd));
            if (e.rw) chk("mem2reg", 32'(oMem2Reg), 32'(e.m2r));
            tick();
        end
        iMemReady = 1'b0;
        iMdDone   = 1'b0;
    endtask

    task automatic do_reset();
        iRST_N    = 1'b0;
        iMemReady = 1'b0;
        iMdDone   = 1'b0;
        tick();
        tick();
        iRST_N = 1'b1;
    endtask

    initial begin
        iRST_N = 1'b0; iOp = 7'd0; iF7b0 = 1'b0; iMemReady = 1'b0; iMdDone = 1'b0;
        tick();

        // Reset state
        do_reset();
        #1;
        chk("rst_state", 32'(oState), 32'd0);
        chk("rst_cycles", 32'(oCycles), 32'd0);
        chk("rst_instret", 32'(oInstret), 32'd0);
        chk("rst_cause", 32'(oTrapCause), 32'd0);
        chk("rst_memwrite", 32'(oMemWrite), 32'd0);
        chk("trapvec", oTrapVec, 32'h0000_0004);

        // ADD: 0,1,2,4,0
        iOp = 7'b0110011; iF7b0 = 1'b0;
        push(4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        push(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(4'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(4'd4, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        push(4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        drain();
        #1;
        chk("add_instret", 32'(oInstret), 32'd1);

        // LOAD with three stalled MEM cycles
        do_reset();
        iOp = 7'b0000011;
        push(4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        push(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(4'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(4'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        push(4'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        push(4'd4, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        push(4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        drain();
        #1;
        chk("load_instret", 32'(oInstret), 32'd1);

        // JAL retires straight out of EXE
        do_reset();
        iOp = 7'b1101111;
        push(4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        push(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(4'd2, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
        push(4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        drain();
        #1;
        chk("jal_instret", 32'(oInstret), 32'd1);

        // Fetch timeout after four stalled FETCH cycles
        do_reset();
        iOp = 7'b0110011;
        for (int i = 0; i < 4; i++) push(4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        drain();
        #1;
        chk("to_state", 32'(oState), 32'd6);
        chk("to_cause", 32'(oTrapCause), 32'd2);
        chk("to_oripc", 32'(oOriPC), 32'd2);
        chk("to_trap", 32'(oTrap), 32'd1);
        chk("to_pcwrite", 32'(oPCWrite), 32'd1);
        tick();
        #1;
        chk("to_after_state", 32'(oState), 32'd0);
        chk("to_cause_held", 32'(oTrapCause), 32'd2);
        chk("to_instret", 32'(oInstret), 32'd0);

        // Illegal opcode traps from DECODE
        do_reset();
        iOp = 7'b1111111;
        push(4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        push(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        drain();
        #1;
        chk("ill_state", 32'(oState), 32'd6);
        chk("ill_cause", 32'(oTrapCause), 32'd1);
        tick();
        #1;
        chk("ill_after_state", 32'(oState), 32'd0);
        chk("ill_instret", 32'(oInstret), 32'd0);

        // Reset during a stalled STORE in MEM
        do_reset();
        iOp = 7'b0100011;
        push(4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        push(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(4'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(4'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        drain();
        #1;
        chk("st_mem_state", 32'(oState), 32'd3);
        chk("st_memwrite", 32'(oMemWrite), 32'd1);
        chk("st_iord", 32'(oIorD), 32'd1);
        iRST_N = 1'b0;
        tick();
        #1;
        chk("st_rst_state", 32'(oState), 32'd0);
        chk("st_rst_memwrite", 32'(oMemWrite), 32'd0);
        chk("st_rst_cycles", 32'(oCycles), 32'd0);
        chk("st_rst_instret", 32'(oInstret), 32'd0);
        iRST_N = 1'b1;
        tick();
        #1;
        chk("st_rel_memwrite", 32'(oMemWrite), 32'd0);
        chk("st_rel_state", 32'(oState), 32'd0);

        // Cycle counter wraps modulo 2^CntW
        do_reset();
        for (int i = 0; i < 300; i++) tick();
        #1;
        chk("cycles_wrap", 32'(oCycles), 32'(300 % 256));

`ifdef CONTROL_MULTI_HS_MULDIV_EN
        // MUL: done arrives on the fifth MULDIV cycle
        do_reset();
        iOp = 7'b0110011; iF7b0 = 1'b1;
        push(4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        push(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        drain();
        #1;
        chk("md_exe_state", 32'(oState), 32'd2);
        chk("md_start", 32'(oMdStart), 32'd1);
        tick();
        #1;
        chk("md_start_off", 32'(oMdStart), 32'd0);
        for (int i = 0; i < 4; i++) push(4'd5, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(4'd5, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        push(4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        drain();
        #1;
        chk("md_instret", 32'(oInstret), 32'd1);
`else
        // Without the M-extension, MUL is illegal
        do_reset();
        iOp = 7'b0110011; iF7b0 = 1'b1;
        push(4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        push(4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        drain();
        #1;
        chk("mul_trap_state", 32'(oState), 32'd6);
        chk("mul_trap_cause", 32'(oTrapCause), 32'd1);
        chk("mdstart_tied", 32'(oMdStart), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_multi_hs.md
CONTROL_MULTI_HS -- requirements
Module: control_multi_hs

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of cycles to wait on iMemReady before trapping; legal range 1..255.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0004, the trap target address driven on oTrapVec.
REQ-004 SHALL have ports, one per line:
- iCLK, in, 1: system clock, rising edge.
- iRST_N, in, 1: reset, synchronous, active-low.
- iOp, in, 7: opcode field of the instruction register.
- iF7b0, in, 1: instr[25], the M-extension selector.
- iMemReady, in, 1: memory access completes this cycle.
- iMdDone, in, 1: mul/div unit result valid.
- oIRWrite, oMemWrite, oMemRead, oIorD, oPCWrite, oPCWriteCond, oRegWrite, oOriAALU, oMdStart, oTrap: out, 1 each.
- oOriPC, oOriBALU, oMem2Reg, oALUOp: out, 2 each.
- oTrapCause, out, 2: 01 = illegal opcode, 10 = memory timeout.
- oTrapVec, out, 32: TRAP_VEC.
- oState, out, 4: present state encoding.
- oCycles, oInstret: out, CNT_W each: cycle counter and retired-instruction counter.

Function
REQ-005 Mux encodings SHALL be:
- oOriAALU: 0 = PC, 1 = A.
- oOriBALU: 00 = B, 01 = 4, 10 = imm.
- oMem2Reg: 00 = ALUOut, 01 = MDR, 10 = PC, 11 = MD result.
- oOriPC: 00 = ALU, 01 = ALUOut, 10 = trap vector.
- oALUOp: 00 = add, 01 = branch compare, 10 = funct decode.
REQ-006 The FSM SHALL have states FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, MULDIV=5, TRAP=6; any other code SHALL go to FETCH on the next cycle.
REQ-007 Outputs SHALL be decoded combinationally from the present state, iOp and the handshake inputs. Every strobe not listed for a state SHALL be 0.
REQ-008 FETCH:
- oMemRead=1, oIorD=0, oOriAALU=0, oOriBALU=01, oALUOp=00 in every FETCH cycle.
- oIRWrite=1 and oPCWrite=1 only in the cycle iMemReady=1; the next state is then DECODE.
- Otherwise the FSM stays in FETCH.
REQ-009 DECODE:
- oOriAALU=0, oOriBALU=10, oALUOp=00 (branch target into ALUOut).
- Next state is EXE for the legal opcodes LOAD 0000011, STORE 0100011, R 0110011, IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Any other opcode goes to TRAP with cause 01.
REQ-010 EXE, per opcode:
- LOAD/STORE: A + imm, next MEM.
- R/IMM: oALUOp=10, oOriAALU=1, oOriBALU = 00 for R and 10 for IMM, next WB.
- BRANCH: oALUOp=01, oOriAALU=1, oPCWriteCond=1, oOriPC=01, next FETCH.
- JAL: oRegWrite=1, oMem2Reg=10, oPCWrite=1, oOriPC=01, next FETCH.
- JALR: oRegWrite=1, oMem2Reg=10, A + imm, oPCWrite=1, oOriPC=00, next FETCH.
- LUI/AUIPC: next WB.
REQ-011 MEM:
- oIorD=1 in every MEM cycle; oMemRead=1 for LOAD, oMemWrite=1 for STORE.
- Waits until iMemReady=1, then LOAD goes to WB and STORE goes to FETCH.
REQ-012 WB: oRegWrite=1, oMem2Reg = 01 for LOAD and 00 otherwise; next state FETCH.
REQ-013 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle with iMemReady=0. When it reaches MEM_TIMEOUT with iMemReady=0, the next state SHALL be TRAP with cause 10. iMemReady=1 in that same cycle SHALL win.
REQ-014 TRAP SHALL last one cycle:
- Asserts oTrap=1, oPCWrite=1, oOriPC=10, with oTrapCause held.
- Next state FETCH.
- oTrapCause SHALL stay registered until the next trap or reset.
REQ-015 Counters:
- oCycles SHALL increment every cycle and wrap modulo 2^CNT_W.
- oInstret SHALL increment once per retirement: the cycle leaving EXE to FETCH, MEM to FETCH (store), WB to FETCH, or MULDIV completion. It SHALL NOT increment on TRAP.
- oInstret SHALL wrap modulo 2^CNT_W.

Reset
REQ-016 Reset SHALL be sampled only at the rising edge of iCLK with iRST_N=0.
REQ-017 On reset: state FETCH, wait counter 0, oCycles=0, oInstret=0, oTrapCause=00.
REQ-018 Reset asserted mid-access SHALL abandon the access. oMemWrite SHALL be 0 in the first cycle after reset release.

Configuration
REQ-019 Macro CONTROL_MULTI_HS_MULDIV_EN:
- When defined, R-type with iF7b0=1 SHALL go from EXE to MULDIV, with oMdStart=1 for exactly the EXE cycle.
- MULDIV waits for iMdDone=1, then asserts oRegWrite=1, oMem2Reg=11 and goes to FETCH.
- When not defined, the MULDIV state, oMdStart and iMdDone SHALL be unused, with oMdStart tied to 0. R-type with iF7b0=1 SHALL then go to TRAP with cause 01.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ADD (0110011) with iMemReady=1 on the first FETCH cycle: states 0,1,2,4,0; oRegWrite=1 only in WB; oInstret 0 to 1.
- LOAD with iMemReady low for 3 MEM cycles: MEM lasts 4 cycles; WB with oMem2Reg=01.
- MEM_TIMEOUT=4, iMemReady held 0 in FETCH: TRAP after 4 FETCH cycles; oTrapCause=10; oOriPC=10; oInstret unchanged.
- iOp=7'b1111111: DECODE to TRAP; oTrapCause=01.
- iRST_N=0 during a STORE in MEM: next state FETCH; oMemWrite=0; counters 0.
- With MULDIV_EN, MUL with iMdDone after 5 cycles: oMdStart pulses once; oRegWrite with oMem2Reg=11 then FETCH.
